// File: rtl/clk_div_monitor_pkg.sv
// Shared types and constants for the divider-chain self-check monitor.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_REPORT
  } state_t;

  localparam int unsigned N_TAPS    = 4;
  localparam int unsigned TAP_DIV2  = 0;
  localparam int unsigned TAP_DIV4  = 1;
  localparam int unsigned TAP_DIV8  = 2;
  localparam int unsigned TAP_DIV16 = 3;

  // Ideal rising-edge count of tap idx (div by 2^(idx+1)) over a window.
  function automatic int unsigned expected_count(input int unsigned window,
                                                 input int unsigned idx);
    return window >> (idx + 1);
  endfunction

endpackage

// File: rtl/clk_div_monitor_if.sv
// Control/result bundle between the monitor and its user.
interface clk_div_monitor_if
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = 9
) ();
  logic [N_TAPS-1:0] div_in;
  logic              start;
  logic [1:0]        cnt_sel;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_TAPS-1:0] err_mask;
  logic [CNT_W-1:0]  cnt_out;

  modport master (
    output div_in, start, cnt_sel,
    input  busy, done, pass, err_mask, cnt_out
  );

  modport slave (
    input  div_in, start, cnt_sel,
    output busy, done, pass, err_mask, cnt_out
  );
endinterface

// File: rtl/clk_div_monitor_edge_sync_det.sv
// Two-flop synchroniser followed by a rising-edge detector for one bit.
module edge_sync_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise_c
);
  logic s1_q, s2_q, prev_q;

  // Capture the asynchronous bit and keep one cycle of history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise_c = s2_q & ~prev_q;
endmodule

// File: rtl/clk_div_monitor.sv
// Measures edge counts of the four divider taps over a fixed window and
// flags any tap whose count deviates from the ideal ratio.
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int unsigned WINDOW = 256,
  parameter int unsigned TOL    = 1,
  parameter int unsigned SETTLE = 3,
  parameter int unsigned CNT_W  = $clog2(WINDOW) + 1
) (
  input  logic            clk,
  input  logic            reset,
  clk_div_monitor_if.slave bus
);
  localparam int unsigned TMR_W = $clog2(WINDOW);
  localparam int unsigned DW    = CNT_W + 1;
  localparam logic signed [DW-1:0] TOL_S = DW'(TOL);

  state_t                        state;
  logic [TMR_W-1:0]              tmr_q;
  logic                          busy_q, done_q, pass_q;
  logic [N_TAPS-1:0]             err_q;
  logic [N_TAPS-1:0]             rise_c;
  logic [N_TAPS-1:0]             err_c;
  logic [N_TAPS-1:0][CNT_W-1:0]  last_cnt;
  logic                          start_acc;

  // A start in the done cycle is still part of the finishing run.
  assign start_acc = (state == ST_IDLE) && bus.start && !done_q;

  // Sequencer: settle (one extra cycle lets the prev flop catch up), measure, report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      tmr_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            state  <= ST_SETTLE;
            tmr_q  <= '0;
            busy_q <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tmr_q == TMR_W'(SETTLE)) begin
            state <= ST_MEASURE;
            tmr_q <= '0;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        ST_MEASURE: begin
          if (tmr_q == TMR_W'(WINDOW - 1)) begin
            state <= ST_REPORT;
            tmr_q <= '0;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        ST_REPORT: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          err_q  <= err_c;
          pass_q <= (err_c == '0);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_TAPS; g++) begin : g_tap
    localparam logic [CNT_W-1:0] EXP = CNT_W'(expected_count(WINDOW, g));

    logic [CNT_W-1:0]     cnt_q, last_q;
    logic signed [DW-1:0] diff_c;

    edge_sync_det u_sync (
      .clk    (clk),
      .reset  (reset),
      .d      (bus.div_in[g]),
      .rise_c (rise_c[g])
    );

    // Saturating edge counter, live only during the measurement window.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (start_acc) begin
        cnt_q <= '0;
      end else if ((state == ST_MEASURE) && rise_c[g] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    // Snapshot of the completed count, shown on cnt_out.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        last_q <= '0;
      end else if (state == ST_REPORT) begin
        last_q <= cnt_q;
      end
    end

    assign diff_c        = $signed({1'b0, cnt_q}) - $signed({1'b0, EXP});
    assign err_c[g]      = (diff_c > TOL_S) || (diff_c < -TOL_S);
    assign last_cnt[g]   = last_q;
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_mask = err_q;
  assign bus.cnt_out  = last_cnt[bus.cnt_sel];
endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: real divider, stuck/slow taps,
// exact-count boundary patterns, protocol and mid-run reset.
module tb_clk_div_monitor;
  import clk_div_pkg::*;

  localparam int CNT_W   = 9;
  localparam int DONE_AT = 261;

  logic clk = 1'b0;
  logic reset;
  int   tests  = 0;
  int   failed = 0;

  int         mode;
  logic [3:0] pat;
  logic [3:0] div_cnt;
  int         n_cfg [4];
  int         done_edge;
  int         done_cycles;
  int         busy0;

  clk_div_monitor_if #(.CNT_W(CNT_W)) bus ();

  clk_div_monitor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference ripple divider: counter bit i is clk / 2^(i+1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_cnt <= 4'd0;
    else       div_cnt <= div_cnt + 4'd1;
  end

  assign bus.div_in = (mode == 0) ? pat :
                      (mode == 1) ? div_cnt :
                      (mode == 2) ? {div_cnt[3], 1'b0, div_cnt[1:0]} :
                                    {div_cnt[3:1], div_cnt[1]};

  // Tap i rises at samples 3,5,7,... n_cfg[i] times (all inside the window).
  function automatic logic [3:0] pat_at(input int k);
    logic [3:0] r;
    for (int i = 0; i < 4; i++)
      r[i] = (k >= 3) && (((k - 3) % 2) == 0) && (((k - 3) / 2) < n_cfg[i]);
    return r;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int got, input int exp, input int tol);
    tests++;
    assert ((got >= exp - tol) && (got <= exp + tol)) else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d+-%0d", tag, got, exp, tol);
    end
  endtask

  task automatic read_cnt(input string tag, input int sel, input int exp, input int tol);
    @(negedge clk);
    bus.cnt_sel = 2'(sel);
    #1;
    chk_near(tag, int'(bus.cnt_out), exp, tol);
  endtask

  // Start sampled at edge k=0; k indexes posedges relative to it.
  task automatic run(input int m, input int restart_k, input int len);
    mode        = m;
    done_edge   = -1;
    done_cycles = 0;
    busy0       = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      pat       = pat_at(k);
      bus.start = (k == 0) || (k == restart_k);
      @(posedge clk);
      #1;
      if (k == 0) busy0 = int'(bus.busy);
      if (bus.done) begin
        if (done_edge < 0) done_edge = k;
        done_cycles++;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    pat       = 4'd0;
  endtask

  task automatic chk_result(input string tag, input int exp_pass, input int exp_err);
    chk({tag, "_done_lat"}, done_edge, DONE_AT);
    chk({tag, "_done_width"}, done_cycles, 1);
    chk({tag, "_pass"}, int'(bus.pass), exp_pass);
    chk({tag, "_err"}, int'(bus.err_mask), exp_err);
  endtask

  task automatic set_n(input int a, input int b, input int c, input int d);
    n_cfg[0] = a; n_cfg[1] = b; n_cfg[2] = c; n_cfg[3] = d;
  endtask

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.cnt_sel = 2'd0;
    mode        = 1;
    pat         = 4'd0;
    set_n(0, 0, 0, 0);

    // Reset and idle with toggling taps.
    repeat (2) @(negedge clk);
    chk("reset_outs", int'({bus.busy, bus.done, bus.pass, bus.err_mask, bus.cnt_out}), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.cnt_sel = 2'(i % 4);
      #1;
      chk("idle_outs", int'({bus.busy, bus.done, bus.pass, bus.err_mask, bus.cnt_out}), 0);
    end

    // Real divider, with a second start at +50 that must be ignored.
    run(1, 50, 266);
    chk("real_busy_set", busy0, 1);
    chk_result("real", 1, 0);
    chk("real_busy_clr", int'(bus.busy), 0);
    read_cnt("real_cnt_div2",  TAP_DIV2,  128, 1);
    read_cnt("real_cnt_div4",  TAP_DIV4,  64,  1);
    read_cnt("real_cnt_div8",  TAP_DIV8,  32,  1);
    read_cnt("real_cnt_div16", TAP_DIV16, 16,  1);
    repeat (10) @(negedge clk);
    chk("hold_pass", int'(bus.pass), 1);
    chk("hold_err", int'(bus.err_mask), 0);

    // div8 stuck low; start in the done cycle must not restart.
    run(2, DONE_AT + 1, 266);
    chk_result("stuck", 0, 4);
    chk("stuck_no_restart", int'(bus.busy), 0);
    read_cnt("stuck_cnt_div8", TAP_DIV8, 0, 0);

    // div2 tap fed with clk/4.
    run(3, -1, 266);
    chk_result("slow", 0, 1);
    read_cnt("slow_cnt_div2", TAP_DIV2, 64, 1);

    // Exact counts at the tolerance boundary: all within +-1.
    set_n(127, 64, 32, 17);
    run(0, -1, 266);
    chk_result("edge_in_hi", 1, 0);
    read_cnt("edge_in_hi_c0", 0, 127, 0);
    read_cnt("edge_in_hi_c3", 3, 17, 0);

    // Off by two on div2 (low) and div16 (high).
    set_n(126, 64, 32, 18);
    run(0, -1, 266);
    chk_result("edge_out_hi", 0, 9);
    read_cnt("edge_out_hi_c0", 0, 126, 0);
    read_cnt("edge_out_hi_c3", 3, 18, 0);

    set_n(128, 63, 33, 15);
    run(0, -1, 266);
    chk_result("edge_in_mix", 1, 0);

    set_n(128, 62, 34, 14);
    run(0, -1, 266);
    chk_result("edge_out_mix", 0, 14);
    read_cnt("edge_out_mix_c1", 1, 62, 0);

    // Reset 100 cycles into a run.
    run(1, -1, 100);
    reset = 1'b1;
    #1;
    chk("abort_outs", int'({bus.busy, bus.done, bus.pass, bus.err_mask, bus.cnt_out}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    done_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_cycles++;
    end
    chk("abort_no_done", done_cycles, 0);
    chk("abort_idle_busy", int'(bus.busy), 0);

    // Fresh run after the abort.
    run(1, -1, 266);
    chk_result("rerun", 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
